// File: rtl/daq_fifo_arbiter_if.sv
// Bundle of the source-FIFO read ports and the host byte stream for daq_fifo_arbiter.
// The master modport is the arbiter side and the slave modport is the environment side.
interface daq_fifo_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic                   en_i;
    logic [NUM_SRC-1:0]     src_empty_i;
    logic [8*NUM_SRC-1:0]   src_data_i;
    logic [NUM_SRC-1:0]     src_req_o;
    logic [7:0]             out_data_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [2:0]             grant_o;
    logic                   busy_o;

    modport master (
        input  en_i, src_empty_i, src_data_i, out_ready_i,
        output src_req_o, out_data_o, out_valid_o, grant_o, busy_o
    );

    modport slave (
        output en_i, src_empty_i, src_data_i, out_ready_i,
        input  src_req_o, out_data_o, out_valid_o, grant_o, busy_o
    );
endinterface

// File: rtl/daq_fifo_arbiter.sv
// Round-robin burst arbiter that drains NUM_SRC packetizer FIFOs into a 2-entry skid stream.
// Optional macro DAQ_ARB_SRC_TAG_EN prefixes each burst with a source tag byte.
module daq_fifo_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int BURST_LEN = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    daq_fifo_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_t;

    localparam logic [7:0] BURST_LIM = 8'(BURST_LEN);
    localparam logic [2:0] LAST_SRC  = 3'(NUM_SRC - 1);

    state_t     state_r;
    logic [2:0] grant_r;
    logic [7:0] count_r;
    logic       inflight_r;
    logic       busy_r;
    logic [1:0] occ_r;
    logic [7:0] ent0_r;
    logic [7:0] ent1_r;

    logic       pop_s;
    logic       credit_s;
    logic       req_s;
    logic       gnt_empty_s;
    logic [7:0] gnt_data_s;
    logic       pick_found_s;
    logic [2:0] pick_idx_s;
    logic       tag_push_s;
    logic       push_s;
    logic [7:0] push_data_s;

    // Granted-source mux for rdempty and q
    always_comb begin
        gnt_empty_s = 1'b1;
        gnt_data_s  = 8'h00;
        for (int k = 0; k < NUM_SRC; k++) begin
            gnt_empty_s = gnt_empty_s & ~((grant_r == 3'(k)) & ~bus.src_empty_i[k]);
            gnt_data_s  = gnt_data_s | ({8{grant_r == 3'(k)}} & bus.src_data_i[8*k +: 8]);
        end
    end

    // Round-robin search starting one past the last grant
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = grant_r;
        for (int i = 1; i <= NUM_SRC; i++) begin
            pick_idx_s   = (!pick_found_s && !bus.src_empty_i[(int'(grant_r) + i) % NUM_SRC])
                           ? 3'((int'(grant_r) + i) % NUM_SRC) : pick_idx_s;
            pick_found_s = pick_found_s | ~bus.src_empty_i[(int'(grant_r) + i) % NUM_SRC];
        end
    end

    // Credit: skid entries plus the read in flight, net of this cycle's pop, must stay below 2
    always_comb begin
        pop_s    = (occ_r != 2'd0) && bus.out_ready_i;
        credit_s = ({1'b0, occ_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s});
        req_s    = (state_r == BURST) && credit_s && !gnt_empty_s && (count_r < BURST_LIM);
`ifdef DAQ_ARB_SRC_TAG_EN
        tag_push_s = (state_r == GRANT) && (occ_r < 2'd2);
`else
        tag_push_s = 1'b0;
`endif
        push_s      = inflight_r | tag_push_s;
        push_data_s = tag_push_s ? {4'hF, 1'b0, grant_r} : gnt_data_s;
    end

    // rdreq decode: only the granted source can ever be read
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            bus.src_req_o[k] = req_s && (grant_r == 3'(k));
        end
    end

    // Arbitration state machine and burst accounting
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r    <= IDLE;
            grant_r    <= LAST_SRC;
            count_r    <= 8'd0;
            inflight_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            inflight_r <= req_s;
            case (state_r)
                IDLE: begin
                    if (bus.en_i && pick_found_s) begin
                        grant_r <= pick_idx_s;
                        busy_r  <= 1'b1;
                        state_r <= GRANT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    count_r <= 8'd0;
`ifdef DAQ_ARB_SRC_TAG_EN
                    state_r <= tag_push_s ? BURST : GRANT;
`else
                    state_r <= BURST;
`endif
                end
                BURST: begin
                    if (req_s) begin
                        count_r <= count_r + 8'd1;
                    end else begin
                        count_r <= count_r;
                    end
                    if ((req_s && (count_r == (BURST_LIM - 8'd1))) ||
                        (count_r == BURST_LIM) || (credit_s && gnt_empty_s)) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= BURST;
                    end
                end
                DRAIN: begin
                    if (!inflight_r && (occ_r == 2'd0)) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Two-entry skid buffer; ent0_r is always the head
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            occ_r  <= 2'd0;
            ent0_r <= 8'h00;
            ent1_r <= 8'h00;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    if (occ_r == 2'd2) begin
                        ent0_r <= ent1_r;
                        ent1_r <= push_data_s;
                    end else begin
                        ent0_r <= push_data_s;
                    end
                end
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        ent0_r <= push_data_s;
                    end else begin
                        ent1_r <= push_data_s;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    ent0_r <= ent1_r;
                    occ_r  <= occ_r - 2'd1;
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign bus.out_valid_o = (occ_r != 2'd0);
    assign bus.out_data_o  = ent0_r;
    assign bus.grant_o     = grant_r;
    assign bus.busy_o      = busy_r;
endmodule

// File: doc/daq_fifo_arbiter.md
Name: daq_fifo_arbiter

Overview:
Round-robin scheduler sharing one byte-wide host link between NUM_SRC packetizer output FIFOs. Grants one FIFO at a time, drains up to BURST_LEN bytes from it, and presents them on a valid/ready byte stream. Sits between the packetizer FIFO read ports (fifo_out_*) and the host interface logic.

Parameters:
NUM_SRC, 4, number of packetizer FIFOs arbitrated (2..8)
BURST_LEN, 64, maximum bytes drained per grant (1..255)

Ports:
clk_i  in  1  system/host-side clock; also drives every source FIFO rdclk
reset_i  in  1  asynchronous, active-low reset
en_i  in  1  arbitration enable; low blocks new grants, the current burst completes
src_empty_i  in  NUM_SRC  per-source FIFO rdempty
src_data_i  in  8*NUM_SRC  per-source FIFO q; source k on bits [8k+7:8k]
src_req_o  out  NUM_SRC  per-source FIFO rdreq; one-hot or zero
out_data_o  out  8  stream byte
out_valid_o  out  1  stream byte valid
out_ready_i  in  1  sink accepts byte when valid and ready are both high
grant_o  out  3  index of the source currently or last granted
busy_o  out  1  high from the first cycle of GRANT until return to IDLE

Behaviour:
- Reset (reset_i low, async): state=IDLE, src_req_o=0, out_valid_o=0, out_data_o=0, grant_o=NUM_SRC-1 so the first grant scans from 0, busy_o=0, skid buffer cleared, burst count=0.
- FIFO read latency is fixed at 1: data for rdreq asserted in cycle n is sampled from src_data_i in cycle n+1.
- Output path is a 2-entry skid FIFO. out_valid_o = occupancy!=0. out_data_o = head entry.
- A transfer occurs when out_valid_o and out_ready_i are both high. The head pops in that cycle.
- A simultaneous pop and land is legal, and occupancy is unchanged.
- Credit rule: rdreq is asserted only if occupancy + inflight - pop_this_cycle < 2. inflight is 0 or 1. Overflow must be impossible. This sustains 1 byte/cycle.
- States:
  - IDLE: if en_i and any src_empty_i bit is low, select the first non-empty source scanning grant_o+1, grant_o+2, ... modulo NUM_SRC. Load grant_o, go to GRANT. Otherwise stay in IDLE.
  - GRANT: one cycle; clear the burst count, busy_o=1, then go to BURST.
  - BURST: src_req_o[grant_o]=1 when the credit rule holds, !src_empty_i[grant_o], and count<BURST_LEN. Count increments per rdreq.
    - Go to DRAIN when count reaches BURST_LEN or the granted FIFO is empty while a credit is available.
  - DRAIN: no rdreq. Wait until inflight=0 and occupancy=0, then go to IDLE with busy_o=0.
- The arbiter never asserts src_req_o on an empty source or on a non-granted source.
- Only src_empty_i[grant_o] is examined during BURST.
- en_i falling mid-burst has no effect until IDLE. en_i low in IDLE keeps the arbiter idle, and the output is already drained.
- out_ready_i held low stalls the burst: rdreq stops after occupancy+inflight=2, with no data loss.
- The count width is 8 bits, and the BURST_LEN comparison is exact, with no wrap.
- A source that refills during DRAIN is not re-granted until its turn comes in round-robin order.

Optional Feature:
Macro DAQ_ARB_SRC_TAG_EN.
- Defined: GRANT pushes a tag byte {4'hF, 1'b0, grant_o} into the skid FIFO before any FIFO read. GRANT then waits in place until occupancy<2. The tag counts toward occupancy but not toward BURST_LEN.
- Undefined: no tag bytes; the stream carries FIFO bytes only.

Test Plan:
- Reset: pulse reset_i low for 3 cycles while src_empty_i=0 -> all outputs are 0, grant_o=3 (NUM_SRC=4), no rdreq during reset or in the first cycle after release.
- Single source: source 2 holds 10 bytes 0x00..0x09, out_ready_i=1 -> bytes 0x00..0x09 in order at 1/cycle, 10 rdreq pulses on src_req_o[2] only, busy_o falls after the last byte, grant_o=2.
- Round-robin plus burst limit: all 4 sources hold 100 bytes, BURST_LEN=64 -> grant order 0,1,2,3,0,1,2,3, bursts of 64,64,64,64,36,36,36,36 bytes, no rdreq on an empty FIFO.
- Backpressure: out_ready_i toggles 1,0,0,1 repeating on a 20-byte source -> at most 2 rdreq run ahead of accepted bytes, all 20 bytes arrive in order, none duplicated or lost.
- Enable gating: drop en_i at byte 5 of a 64-byte burst -> the burst completes all 64 bytes, then IDLE with no new grant until en_i rises again.
- DAQ_ARB_SRC_TAG_EN defined: sources 1 and 3 hold 2 bytes each -> stream is 0xF1,d,d,0xF3,d,d.
